// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and valid/ready handshake.
// Optional RR_ARB_LOCK_EN adds a lock input that holds the priority pointer.
module rr_onehot_arbiter #(
    parameter int NUM_REQ = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               gnt_valid,
    output logic [NUM_REQ-1:0] gnt_onehot,
`ifdef RR_ARB_LOCK_EN
    input  logic               lock,
`endif
    input  logic               gnt_ready
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    generate
        if (NUM_REQ < 2) begin : g_bad_param
            $error("rr_onehot_arbiter: NUM_REQ must be at least 2");
        end
    endgenerate

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ptr_q, ptr_d;

    logic               hs;
    logic               lock_eff;
    logic               hold_same;
    logic [NUM_REQ-1:0] ptr_adv;
    logic [NUM_REQ-1:0] ptr_src;
    logic [NUM_REQ-1:0] sel;

    // Lowest set bit at or above the one-hot pointer, else lowest set bit overall.
    function automatic logic [NUM_REQ-1:0] pick(
        input logic [NUM_REQ-1:0] r,
        input logic [NUM_REQ-1:0] p
    );
        logic [NUM_REQ-1:0] therm;
        logic [NUM_REQ-1:0] hi;
        therm = ~(p - ONE);
        hi    = r & therm;
        if (|hi) begin
            pick = hi & (~hi + ONE);
        end else begin
            pick = r & (~r + ONE);
        end
    endfunction

`ifdef RR_ARB_LOCK_EN
    assign lock_eff = lock;
`else
    assign lock_eff = 1'b0;
`endif

    assign hs        = valid_q & gnt_ready;
    assign ptr_adv   = {gnt_q[NUM_REQ-2:0], gnt_q[NUM_REQ-1]};
    assign ptr_src   = (hs && !lock_eff) ? ptr_adv : ptr_q;
    assign hold_same = lock_eff & (|(req & gnt_q));
    assign sel       = pick(req, ptr_src);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = sel;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (hs) begin
                    ptr_d = ptr_src;
                    if (hold_same) begin
                        gnt_d = gnt_q;
                    end else if (|req) begin
                        gnt_d = sel;
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            gnt_q   <= '0;
            ptr_q   <= ONE;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_valid  = valid_q;
    assign gnt_onehot = gnt_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed and random stimulus for rr_onehot_arbiter against an index-based
// round-robin model; lock scenarios only when RR_ARB_LOCK_EN is defined.
module tb_rr_onehot_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         gnt_ready;
    logic         lock;
    logic         gnt_valid;
    logic [N-1:0] gnt_onehot;

    int checks;
    int failures;

    // Reference model: integer pointer and granted index.
    int m_ptr;
    bit m_valid;
    int m_idx;

    rr_onehot_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
`ifdef RR_ARB_LOCK_EN
        .lock       (lock),
`endif
        .gnt_ready  (gnt_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int search(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_oh();
        logic [N-1:0] v;
        v = '0;
        if (m_valid) v[m_idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_idx   = 0;
    endtask

    task automatic model_edge();
        int  s;
        bit  lk;
`ifdef RR_ARB_LOCK_EN
        lk = lock;
`else
        lk = 0;
`endif
        if (!rst_n) begin
            model_reset();
        end else if (!m_valid) begin
            s = search(req, m_ptr);
            if (s >= 0) begin
                m_valid = 1;
                m_idx   = s;
            end
        end else if (gnt_ready) begin
            if (!lk) m_ptr = (m_idx + 1) % N;
            if (!(lk && req[m_idx])) begin
                s = search(req, m_ptr);
                if (s >= 0) m_idx = s;
                else m_valid = 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", 32'({gnt_valid, gnt_onehot}),
            32'({m_valid, model_oh()}));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_reset();
        req       = '0;
        gnt_ready = 1'b0;
        lock      = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        req       = 8'hFF;
        #1;
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        chk("rst_onehot", 32'(gnt_onehot), 32'h00);
        cyc();
        cyc();
        chk("rst_hold", 32'(gnt_onehot), 32'h00);

        req   = 8'h00;
        rst_n = 1'b1;
        repeat (10) cyc();
        chk("idle_valid", 32'(gnt_valid), 32'd0);
        chk("idle_onehot", 32'(gnt_onehot), 32'h00);

        // Full rotation with no bubbles.
        req       = 8'hFF;
        gnt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("rotate", 32'({gnt_valid, gnt_onehot}),
                32'({1'b1, 8'(1 << (i % N))}));
        end
        req = 8'h00;
        cyc();
        chk("rot_drain", 32'(gnt_valid), 32'd0);

        // Backpressure; pointer now 1.
        req       = 8'h24;
        gnt_ready = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold", 32'({gnt_valid, gnt_onehot}), 32'h104);
        end
        gnt_ready = 1'b1;
        cyc();
        chk("bp_next", 32'(gnt_onehot), 32'h20);
        cyc();
        chk("bp_wrap", 32'(gnt_onehot), 32'h04);
        req = 8'h00;
        cyc();

        // Wrap past the top requester; pointer now 3.
        req       = 8'h81;
        gnt_ready = 1'b0;
        cyc();
        chk("wrap_80", 32'(gnt_onehot), 32'h80);
        gnt_ready = 1'b1;
        cyc();
        chk("wrap_01", 32'(gnt_onehot), 32'h01);
        req = 8'h00;
        cyc();

        // Withdraw while granted.
        req       = 8'h08;
        gnt_ready = 1'b0;
        cyc();
        chk("wd_grant", 32'(gnt_onehot), 32'h08);
        req = 8'h00;
        repeat (3) begin
            cyc();
            chk("wd_hold", 32'({gnt_valid, gnt_onehot}), 32'h108);
        end
        gnt_ready = 1'b1;
        cyc();
        chk("wd_done", 32'(gnt_valid), 32'd0);

        // Asynchronous reset mid-grant.
        req       = 8'h10;
        gnt_ready = 1'b0;
        cyc();
        chk("ar_grant", 32'(gnt_onehot), 32'h10);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_valid", 32'(gnt_valid), 32'd0);
        chk("ar_onehot", 32'(gnt_onehot), 32'h00);
        req = 8'hFF;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("ar_first", 32'(gnt_onehot), 32'h01);

`ifdef RR_ARB_LOCK_EN
        req       = 8'h06;
        lock      = 1'b1;
        gnt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("lock_hold", 32'(gnt_onehot), 32'h02);
        end
        lock = 1'b0;
        cyc();
        chk("lock_rel", 32'(gnt_onehot), 32'h04);
        lock = 1'b0;
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            req       = 8'($urandom) & 8'($urandom);
            gnt_ready = 1'($urandom_range(0, 2) != 0);
`ifdef RR_ARB_LOCK_EN
            lock      = 1'($urandom_range(0, 3) == 0);
`endif
            cyc();
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("rand_rst", 32'({gnt_valid, gnt_onehot}), 32'h000);
                cyc();
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
